mux_2to1: RTL and testbench
===========================

Name: mux_2to1

Overview:
- Parameterised 2:1 selector with a combinational output and a registered copy of that output.
- sel=0 passes a; sel=1 passes b.
- Used as a leaf datapath primitive wherever two sources feed one sink.
- The registered path gives downstream logic a timing-clean, reset-defined version of the selection.

Parameters:
- WIDTH, 1, bit width of a, b, y, y_q.
- CNT_W, 16, width of the select-toggle counter (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  data source selected when sel=0.
- b  input  WIDTH  data source selected when sel=1.
- sel  input  1  select.
- y  output  WIDTH  combinational selection.
- y_q  output  WIDTH  registered selection.
- sel_q  output  1  registered sel.
- sel_toggles  output  CNT_W  select-toggle count (present only with MUX_2TO1_SEL_CNT_EN).

Behaviour:
- y = sel ? b : a.
  - Purely combinational, zero latency, no dependence on clk or rst_n.
  - Must settle within the same timestep as an input change.
- Truth table for WIDTH=1, as (a,b,sel -> y):
  - 000->0, 010->0, 011->1, 100->1, 101->0, 110->1, 111->1.
  - 001->0.
- y_q and sel_q:
  - On each rising clk edge with rst_n=1: y_q <= current y, sel_q <= sel. One-cycle latency.
  - rst_n low: y_q=0 and sel_q=0 immediately (asynchronous), held while low.
  - First update happens at the first rising edge after rst_n deasserts.
- Reset mid-operation:
  - Registered outputs clear at once.
  - y keeps following its inputs throughout reset.
- X/Z on sel: no special handling required. Benches drive only known values.
- No handshake. Every cycle is valid.

Optional Feature:
- Macro MUX_2TO1_SEL_CNT_EN.
- When defined:
  - Adds the sel_toggles output port and a CNT_W-bit counter.
  - The counter increments on each rising edge where sel != sel_q.
  - Saturates at all-ones and does not wrap.
  - Reset value 0 (asynchronous, rst_n low).
- When undefined:
  - The port and counter do not exist.
  - All other behaviour is identical.

Decomposition:
- Package mux_2to1_pkg:
  - Default width constants: MUX_2TO1_DEF_WIDTH=1, MUX_2TO1_DEF_CNT_W=16.
  - Reset value constant for y_q (all zeros).
- Optional sub-module mux_2to1_sel_cnt holds the saturating toggle counter. It is instantiated only under MUX_2TO1_SEL_CNT_EN.
- The core select and output register stay in mux_2to1.

Test Plan:
- Combinational truth table, WIDTH=1, each vector held 10 ns, y checked:
  - (a,b,sel) = 000, 010, 011, 100, 101, 110, 111 -> y = 0, 0, 1, 1, 0, 1, 1.
- Registered latency, WIDTH=8:
  - a=8'hA5, b=8'h3C.
  - sel=0 then sel=1 on consecutive cycles -> y_q = 8'hA5 then 8'h3C, each one edge after the change.
  - sel_q tracks sel with the same one-edge delay.
- Async reset:
  - With y_q=8'h3C, drop rst_n between edges -> y_q=0 and sel_q=0 before the next edge.
  - y still equals 8'h3C during reset.
  - Release rst_n -> y_q=8'h3C after the first edge.
- Wide data, WIDTH=32:
  - a=32'hDEADBEEF, b=32'h12345678.
  - Toggle sel -> y alternates between the two values exactly, with no bit mixing.
- Optional counter, MUX_2TO1_SEL_CNT_EN, CNT_W=2:
  - Toggle sel on 5 consecutive cycles after reset -> sel_toggles = 1, 2, 3, 3, 3 (saturates).
  - Reset -> 0.

Source files
------------

// File: rtl/mux_2to1_pkg.sv
// mux_2to1_pkg: shared defaults and reset value for the mux_2to1 selector.
package mux_2to1_pkg;
    localparam int MUX_2TO1_DEF_WIDTH = 1;
    localparam int MUX_2TO1_DEF_CNT_W = 16;
    localparam logic MUX_2TO1_RST_BIT = 1'b0;
endpackage

// File: rtl/mux_2to1_sel_cnt.sv
// mux_2to1_sel_cnt: saturating select-toggle counter, used when MUX_2TO1_SEL_CNT_EN is defined.
module mux_2to1_sel_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/mux_2to1.sv
// mux_2to1: 2:1 selector with combinational y and registered y_q/sel_q.
// Optional select-toggle counter enabled by defining MUX_2TO1_SEL_CNT_EN.
module mux_2to1
    import mux_2to1_pkg::*;
#(
    parameter int WIDTH = MUX_2TO1_DEF_WIDTH
`ifdef MUX_2TO1_SEL_CNT_EN
    , parameter int CNT_W = MUX_2TO1_DEF_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             sel_q
`ifdef MUX_2TO1_SEL_CNT_EN
    , output logic [CNT_W-1:0] sel_toggles
`endif
);
    always_comb y = sel ? b : a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= {WIDTH{MUX_2TO1_RST_BIT}};
            sel_q <= 1'b0;
        end else begin
            y_q   <= y;
            sel_q <= sel;
        end
    end

`ifdef MUX_2TO1_SEL_CNT_EN
    mux_2to1_sel_cnt #(.CNT_W(CNT_W)) u_sel_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sel != sel_q),
        .count (sel_toggles)
    );
`endif
endmodule

// File: tb/tb_mux_2to1.sv
// tb_mux_2to1: directed checks of mux_2to1 at WIDTH 1, 8 and 32, plus the
// saturating toggle counter when MUX_2TO1_SEL_CNT_EN is defined.
module tb_mux_2to1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    logic        a1 = 1'b0, b1 = 1'b0, s1 = 1'b0, y1, yq1, sq1;
    logic [7:0]  a8 = '0, b8 = '0, y8, yq8;
    logic        s8 = 1'b0, sq8;
    logic [31:0] a32 = '0, b32 = '0, y32, yq32;
    logic        s32 = 1'b0, sq32;

    always #5 clk = ~clk;

    mux_2to1 #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(s1),
        .y(y1), .y_q(yq1), .sel_q(sq1)
    );
    mux_2to1 #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sel(s8),
        .y(y8), .y_q(yq8), .sel_q(sq8)
    );
    mux_2to1 #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .sel(s32),
        .y(y32), .y_q(yq32), .sel_q(sq32)
    );

`ifdef MUX_2TO1_SEL_CNT_EN
    logic       sc = 1'b0, sqc;
    logic [1:0] ac = '0, bc = '0, yc, yqc, cnt;
    mux_2to1 #(.WIDTH(2), .CNT_W(2)) uc (
        .clk(clk), .rst_n(rst_n), .a(ac), .b(bc), .sel(sc),
        .y(yc), .y_q(yqc), .sel_q(sqc), .sel_toggles(cnt)
    );
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // each entry is {a, b, sel, expected y}
    logic [3:0] tt [7] = '{4'b0000, 4'b0100, 4'b0111, 4'b1001, 4'b1010, 4'b1101, 4'b1111};
    logic [2:0] sat [5] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3};

    initial begin
        #1;
        check("rst_yq8", {24'h0, yq8}, 32'h0);
        check("rst_selq8", {31'h0, sq8}, 32'h0);
        for (int i = 0; i < 7; i++) begin
            {a1, b1, s1} = tt[i][3:1];
            #10;
            check($sformatf("tt%0d", i), {31'h0, y1}, {31'h0, tt[i][0]});
        end
        @(negedge clk);
        rst_n = 1'b1;
        a8 = 8'hA5;
        b8 = 8'h3C;
        s8 = 1'b0;
        @(posedge clk);
        #1;
        check("lat_yq_a", {24'h0, yq8}, 32'hA5);
        check("lat_selq0", {31'h0, sq8}, 32'h0);
        s8 = 1'b1;
        #1;
        check("lat_y_b", {24'h0, y8}, 32'h3C);
        check("lat_yq_hold", {24'h0, yq8}, 32'hA5);
        @(posedge clk);
        #1;
        check("lat_yq_b", {24'h0, yq8}, 32'h3C);
        check("lat_selq1", {31'h0, sq8}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_yq", {24'h0, yq8}, 32'h0);
        check("arst_selq", {31'h0, sq8}, 32'h0);
        check("arst_y", {24'h0, y8}, 32'h3C);
        @(negedge clk);
        check("arst_hold", {24'h0, yq8}, 32'h0);
        rst_n = 1'b1;
        #1;
        check("rel_pre_edge", {24'h0, yq8}, 32'h0);
        @(posedge clk);
        #1;
        check("rel_yq", {24'h0, yq8}, 32'h3C);
        check("rel_selq", {31'h0, sq8}, 32'h1);
        a32 = 32'hDEADBEEF;
        b32 = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            s32 = i[0];
            #3;
            check($sformatf("wide%0d", i), y32, i[0] ? 32'h12345678 : 32'hDEADBEEF);
        end
`ifdef MUX_2TO1_SEL_CNT_EN
        @(negedge clk);
        rst_n = 1'b0;
        sc = 1'b0;
        #1;
        check("cnt_rst", {30'h0, cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sc = ~sc;
            @(posedge clk);
            #1;
            check($sformatf("cnt%0d", i), {30'h0, cnt}, {29'h0, sat[i]});
        end
        rst_n = 1'b0;
        #1;
        check("cnt_rst2", {30'h0, cnt}, 32'h0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
